// File: rtl/check.sv
// check: result checker that sits downstream of the stimulus sequencer.
//
// It pops one expected-result entry from CHECK_FIFO and one actual output
// vector from OUT_FIFO in the same cycle. It masks their difference with the
// current output bitmask and writes one record per vector into RES_FIFO. It
// also keeps saturating pass/fail counters. The STIM<=>CHECK command interface
// handles a single command, the bitmask load.
//
// Ports:
//   clock, reset_n      system clock, asynchronous active-low reset
//   cfifo_*             CHECK_FIFO read side (show-ahead head, rdreq, rdempty)
//                       head = {expected, address, reserved or-value}
//   ofifo_*             OUT_FIFO read side (show-ahead head, rdreq, rdempty)
//   rfifo_*             RES_FIFO write side, record = {fail, address, mismatch}
//   sc_cmd, sc_data     command and payload (BITMASK = 5'b00001)
//   sc_switching        target/Vdd switch in progress; blocks new pops
//   sc_ready            command interface ready (checker idle)
//   pass_count          saturating count of passing vectors
//   fail_count          saturating count of failing vectors
module check #(
  parameter int ADDR_WIDTH = 20,
  parameter int STF_WIDTH  = 24,
  parameter int ORV_WIDTH  = 8,
  parameter int CHF_WIDTH  = STF_WIDTH + ORV_WIDTH + ADDR_WIDTH,
  parameter int SCC_WIDTH  = 5,
  parameter int SCD_WIDTH  = 24,
  parameter int RES_WIDTH  = 1 + ADDR_WIDTH + STF_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [CHF_WIDTH-1:0] cfifo_data,
  output logic                 cfifo_rdreq,
  input  logic                 cfifo_rdempty,
  input  logic [STF_WIDTH-1:0] ofifo_data,
  output logic                 ofifo_rdreq,
  input  logic                 ofifo_rdempty,
  output logic [RES_WIDTH-1:0] rfifo_data,
  output logic                 rfifo_wrreq,
  input  logic                 rfifo_wrfull,
  input  logic [SCC_WIDTH-1:0] sc_cmd,
  input  logic [SCD_WIDTH-1:0] sc_data,
  input  logic                 sc_switching,
  output logic                 sc_ready,
  output logic [CNT_WIDTH-1:0] pass_count,
  output logic [CNT_WIDTH-1:0] fail_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  localparam logic [SCC_WIDTH-1:0] CMD_BITMASK = SCC_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [STF_WIDTH-1:0]   exp_q, exp_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [STF_WIDTH-1:0]   act_q, act_d;
  logic [STF_WIDTH-1:0]   mismatch_q, mismatch_d;
  logic                   fail_q, fail_d;
  logic [STF_WIDTH-1:0]   mask_q, mask_d;
  logic [CNT_WIDTH-1:0]   pass_count_q, pass_count_d;
  logic [CNT_WIDTH-1:0]   fail_count_q, fail_count_d;
  logic                   pop;
  logic                   wr;
  logic [STF_WIDTH-1:0]   diff;

  // The or-value field is reserved and never takes part in the compare.
  logic unused_orv;
  assign unused_orv = ^cfifo_data[ORV_WIDTH-1:0];

  // Next-state logic. Both FIFOs are always popped together. RES_FIFO fullness
  // is sampled only before popping, so the WR cycle always has a free slot.
  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    addr_d       = addr_q;
    act_d        = act_q;
    mismatch_d   = mismatch_q;
    fail_d       = fail_q;
    mask_d       = mask_q;
    pass_count_d = pass_count_q;
    fail_count_d = fail_count_q;
    pop          = 1'b0;
    wr           = 1'b0;
    diff         = (exp_q ^ act_q) & mask_q;

    case (state_q)
      ST_IDLE: begin
        if (!cfifo_rdempty && !ofifo_rdempty && !rfifo_wrfull && !sc_switching) begin
          pop     = 1'b1;
          exp_d   = cfifo_data[CHF_WIDTH-1 -: STF_WIDTH];
          addr_d  = cfifo_data[CHF_WIDTH-STF_WIDTH-1 -: ADDR_WIDTH];
          act_d   = ofifo_data;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        mismatch_d = diff;
        fail_d     = |diff;
        state_d    = ST_WR;
      end
      ST_WR: begin
        wr = 1'b1;
        if (fail_q) begin
          if (fail_count_q != {CNT_WIDTH{1'b1}}) fail_count_d = fail_count_q + CNT_WIDTH'(1);
        end else begin
          if (pass_count_q != {CNT_WIDTH{1'b1}}) pass_count_d = pass_count_q + CNT_WIDTH'(1);
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A bitmask loaded in the same cycle as a pop already applies to that
    // vector, because CMP reads the registered mask one cycle later.
    if (state_q == ST_IDLE && sc_cmd == CMD_BITMASK) mask_d = sc_data[STF_WIDTH-1:0];
  end

  // State and datapath registers. Reset drops any in-flight vector.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      exp_q        <= '0;
      addr_q       <= '0;
      act_q        <= '0;
      mismatch_q   <= '0;
      fail_q       <= 1'b0;
      mask_q       <= '1;
      pass_count_q <= '0;
      fail_count_q <= '0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      addr_q       <= addr_d;
      act_q        <= act_d;
      mismatch_q   <= mismatch_d;
      fail_q       <= fail_d;
      mask_q       <= mask_d;
      pass_count_q <= pass_count_d;
      fail_count_q <= fail_count_d;
    end
  end

  assign cfifo_rdreq = pop;
  assign ofifo_rdreq = pop;
  assign rfifo_wrreq = wr;
  assign rfifo_data  = {fail_q, addr_q, mismatch_q};
  assign sc_ready    = (state_q == ST_IDLE);
  assign pass_count  = pass_count_q;
  assign fail_count  = fail_count_q;

endmodule

// File: tb/tb_check.sv
// tb_check: directed self-checking bench for the check block.
// Each feature has its own task that drives the FIFO flags and heads plus
// the command interface, then compares outputs against hand-computed values.
module tb_check;

  localparam int ADDR = 20;
  localparam int STF  = 24;
  localparam int CHF  = 52;
  localparam int RES  = 45;
  localparam int CNT  = 16;

  logic            clock;
  logic            reset_n;
  logic [CHF-1:0]  cfifo_data;
  logic            cfifo_rdreq;
  logic            cfifo_rdempty;
  logic [STF-1:0]  ofifo_data;
  logic            ofifo_rdreq;
  logic            ofifo_rdempty;
  logic [RES-1:0]  rfifo_data;
  logic            rfifo_wrreq;
  logic            rfifo_wrfull;
  logic [4:0]      sc_cmd;
  logic [23:0]     sc_data;
  logic            sc_switching;
  logic            sc_ready;
  logic [CNT-1:0]  pass_count;
  logic [CNT-1:0]  fail_count;

  int checks;
  int errors;

  check dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .cfifo_data    (cfifo_data),
    .cfifo_rdreq   (cfifo_rdreq),
    .cfifo_rdempty (cfifo_rdempty),
    .ofifo_data    (ofifo_data),
    .ofifo_rdreq   (ofifo_rdreq),
    .ofifo_rdempty (ofifo_rdempty),
    .rfifo_data    (rfifo_data),
    .rfifo_wrreq   (rfifo_wrreq),
    .rfifo_wrfull  (rfifo_wrfull),
    .sc_cmd        (sc_cmd),
    .sc_data       (sc_data),
    .sc_switching  (sc_switching),
    .sc_ready      (sc_ready),
    .pass_count    (pass_count),
    .fail_count    (fail_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Offers one vector to the DUT and collects what it does with it.
  // mode 0: plain; mode 1: BITMASK load in the pop cycle;
  // mode 2: BITMASK request raised during CMP. Returns at the WR-cycle negedge.
  task automatic run_vector(input logic [23:0] exp_v, input logic [23:0] act_v,
                            input logic [19:0] addr_v, input int mode,
                            input logic [23:0] cmd_mask,
                            output logic popped, output logic wr_cmp,
                            output logic ready_cmp, output logic wr_wr,
                            output logic [RES-1:0] rec);
    popped = 1'b0; wr_cmp = 1'b0; ready_cmp = 1'b0; wr_wr = 1'b0; rec = '0;
    @(negedge clock);
    cfifo_data    = {exp_v, addr_v, 8'h5A};
    ofifo_data    = act_v;
    cfifo_rdempty = 1'b0;
    ofifo_rdempty = 1'b0;
    if (mode == 1) begin sc_cmd = 5'd1; sc_data = cmd_mask; end
    for (int i = 0; i < 20 && !popped; i++) begin
      #1;
      if (cfifo_rdreq && ofifo_rdreq) popped = 1'b1;
      else @(negedge clock);
    end
    if (popped) begin
      @(posedge clock);
      #1;
      cfifo_rdempty = 1'b1;
      ofifo_rdempty = 1'b1;
      sc_cmd = 5'd0;
      @(negedge clock);
      wr_cmp    = rfifo_wrreq;
      ready_cmp = sc_ready;
      if (mode == 2) begin sc_cmd = 5'd1; sc_data = cmd_mask; end
      @(negedge clock);
      wr_wr = rfifo_wrreq;
      rec   = rfifo_data;
      sc_cmd = 5'd0;
    end else begin
      cfifo_rdempty = 1'b1;
      ofifo_rdempty = 1'b1;
      sc_cmd = 5'd0;
    end
  endtask

  task automatic load_mask(input logic [23:0] m);
    @(negedge clock);
    sc_cmd = 5'd1; sc_data = m;
    @(negedge clock);
    sc_cmd = 5'd0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (sc_ready !== 1'b1 || cfifo_rdreq !== 1'b0 || ofifo_rdreq !== 1'b0 || rfifo_wrreq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got ready=%b cr=%b or=%b wr=%b want 1 0 0 0", sc_ready, cfifo_rdreq, ofifo_rdreq, rfifo_wrreq);
    end
    checks++;
    if (rfifo_data !== '0 || pass_count !== 16'h0 || fail_count !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_data got rec=%h pass=%h fail=%h want 0 0 0", rfifo_data, pass_count, fail_count);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_pass;
    logic p, wc, rc, ww; logic [RES-1:0] r;
    run_vector(24'hA5A5A5, 24'hA5A5A5, 20'h00012, 0, 24'h0, p, wc, rc, ww, r);
    checks++;
    if (p !== 1'b1 || wc !== 1'b0 || ww !== 1'b1) begin
      errors++; $display("[TB] FAIL pass_timing got pop=%b wr_cmp=%b wr_wr=%b want 1 0 1", p, wc, ww);
    end
    checks++;
    if (r !== {1'b0, 20'h00012, 24'h000000}) begin
      errors++; $display("[TB] FAIL pass_record got %h want %h", r, {1'b0, 20'h00012, 24'h000000});
    end
    @(negedge clock);
    checks++;
    if (pass_count !== 16'd1 || fail_count !== 16'd0 || rfifo_wrreq !== 1'b0) begin
      errors++; $display("[TB] FAIL pass_count got pass=%h fail=%h wr=%b want 1 0 0", pass_count, fail_count, rfifo_wrreq);
    end
  endtask

  task automatic test_fail;
    logic p, wc, rc, ww; logic [RES-1:0] r;
    run_vector(24'h0000FF, 24'h0000F0, 20'h00034, 0, 24'h0, p, wc, rc, ww, r);
    checks++;
    if (p !== 1'b1 || ww !== 1'b1 || r !== {1'b1, 20'h00034, 24'h00000F}) begin
      errors++; $display("[TB] FAIL fail_record got pop=%b wr=%b rec=%h want 1 1 %h", p, ww, r, {1'b1, 20'h00034, 24'h00000F});
    end
    @(negedge clock);
    checks++;
    if (fail_count !== 16'd1 || pass_count !== 16'd1) begin
      errors++; $display("[TB] FAIL fail_count got pass=%h fail=%h want 1 1", pass_count, fail_count);
    end
  endtask

  task automatic test_bitmask;
    logic p, wc, rc, ww; logic [RES-1:0] r;
    load_mask(24'hFFFFF0);
    run_vector(24'h0000FF, 24'h0000F0, 20'hABCDE, 0, 24'h0, p, wc, rc, ww, r);
    checks++;
    if (p !== 1'b1 || ww !== 1'b1 || r !== {1'b0, 20'hABCDE, 24'h000000}) begin
      errors++; $display("[TB] FAIL mask_record got pop=%b wr=%b rec=%h want 1 1 %h", p, ww, r, {1'b0, 20'hABCDE, 24'h000000});
    end
    @(negedge clock);
    checks++;
    if (pass_count !== 16'd2 || fail_count !== 16'd1) begin
      errors++; $display("[TB] FAIL mask_count got pass=%h fail=%h want 2 1", pass_count, fail_count);
    end
  endtask

  task automatic test_mask_with_pop;
    logic p, wc, rc, ww; logic [RES-1:0] r;
    run_vector(24'h123456, 24'h654321, 20'hFFFFF, 1, 24'h000000, p, wc, rc, ww, r);
    checks++;
    if (p !== 1'b1 || ww !== 1'b1 || r !== {1'b0, 20'hFFFFF, 24'h000000}) begin
      errors++; $display("[TB] FAIL mask_same_cycle got pop=%b wr=%b rec=%h want 1 1 %h", p, ww, r, {1'b0, 20'hFFFFF, 24'h000000});
    end
    @(negedge clock);
    checks++;
    if (pass_count !== 16'd3) begin
      errors++; $display("[TB] FAIL mask_same_cycle_count got pass=%h want 3", pass_count);
    end
  endtask

  task automatic test_mask_during_cmp;
    logic p, wc, rc, ww; logic [RES-1:0] r;
    load_mask(24'hFFFFFF);
    run_vector(24'h0000FF, 24'h0000F0, 20'h00056, 2, 24'h000000, p, wc, rc, ww, r);
    checks++;
    if (rc !== 1'b0) begin
      errors++; $display("[TB] FAIL ready_in_cmp got %b want 0", rc);
    end
    checks++;
    if (p !== 1'b1 || r !== {1'b1, 20'h00056, 24'h00000F}) begin
      errors++; $display("[TB] FAIL cmd_in_cmp_record got pop=%b rec=%h want 1 %h", p, r, {1'b1, 20'h00056, 24'h00000F});
    end
    // A follow-up vector shows the ignored command left the mask alone.
    run_vector(24'h0000FF, 24'h0000F0, 20'h00057, 0, 24'h0, p, wc, rc, ww, r);
    checks++;
    if (p !== 1'b1 || r !== {1'b1, 20'h00057, 24'h00000F}) begin
      errors++; $display("[TB] FAIL mask_unchanged got pop=%b rec=%h want 1 %h", p, r, {1'b1, 20'h00057, 24'h00000F});
    end
    @(negedge clock);
    checks++;
    if (fail_count !== 16'd3 || pass_count !== 16'd3) begin
      errors++; $display("[TB] FAIL cmd_in_cmp_count got pass=%h fail=%h want 3 3", pass_count, fail_count);
    end
  endtask

  task automatic test_stall;
    logic seen;
    logic p, wc, rc, ww; logic [RES-1:0] r;
    @(negedge clock);
    cfifo_data = {24'h111111, 20'h00099, 8'h00}; ofifo_data = 24'h111111;
    cfifo_rdempty = 1'b0; ofifo_rdempty = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1; if (cfifo_rdreq || ofifo_rdreq) seen = 1'b1;
      @(negedge clock);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_ofifo_empty got rdreq=%b want 0", seen);
    end
    ofifo_rdempty = 1'b0; rfifo_wrfull = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1; if (cfifo_rdreq || ofifo_rdreq) seen = 1'b1;
      @(negedge clock);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_wrfull got rdreq=%b want 0", seen);
    end
    rfifo_wrfull = 1'b0; sc_switching = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1; if (cfifo_rdreq || ofifo_rdreq) seen = 1'b1;
      @(negedge clock);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_switching got rdreq=%b want 0", seen);
    end
    sc_switching = 1'b0;
    cfifo_rdempty = 1'b1; ofifo_rdempty = 1'b1;
    run_vector(24'h111111, 24'h111111, 20'h00099, 0, 24'h0, p, wc, rc, ww, r);
    checks++;
    if (p !== 1'b1 || r !== {1'b0, 20'h00099, 24'h000000}) begin
      errors++; $display("[TB] FAIL stall_release got pop=%b rec=%h want 1 %h", p, r, {1'b0, 20'h00099, 24'h000000});
    end
    @(negedge clock);
    checks++;
    if (pass_count !== 16'd4) begin
      errors++; $display("[TB] FAIL stall_release_count got pass=%h want 4", pass_count);
    end
  endtask

  task automatic test_saturation;
    logic p, wc, rc, ww; logic [RES-1:0] r;
    @(negedge clock);
    force dut.fail_count_q = 16'hFFFE;
    @(negedge clock);
    release dut.fail_count_q;
    for (int i = 0; i < 3; i++) begin
      run_vector(24'h800000, 24'h000000, 20'h00100, 0, 24'h0, p, wc, rc, ww, r);
      @(negedge clock);
      checks++;
      if (p !== 1'b1 || fail_count !== 16'hFFFF) begin
        errors++; $display("[TB] FAIL fail_saturate[%0d] got pop=%b fail=%h want 1 ffff", i, p, fail_count);
      end
    end
    checks++;
    if (pass_count !== 16'd4) begin
      errors++; $display("[TB] FAIL saturate_pass_untouched got %h want 4", pass_count);
    end
  endtask

  task automatic test_reset_mid_vector;
    logic seen;
    logic p, wc, rc, ww; logic [RES-1:0] r;
    load_mask(24'hFFFFF0);
    @(negedge clock);
    cfifo_data = {24'h0000FF, 20'h00077, 8'h00}; ofifo_data = 24'h0000F0;
    cfifo_rdempty = 1'b0; ofifo_rdempty = 1'b0;
    #1;
    checks++;
    if (cfifo_rdreq !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_mid_pop got %b want 1", cfifo_rdreq);
    end
    @(posedge clock);
    #1;
    cfifo_rdempty = 1'b1; ofifo_rdempty = 1'b1;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if (pass_count !== 16'h0 || fail_count !== 16'h0 || sc_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_mid_state got pass=%h fail=%h ready=%b want 0 0 1", pass_count, fail_count, sc_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (rfifo_wrreq) seen = 1'b1;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (rfifo_wrreq) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_mid_no_write got wrreq=%b want 0", seen);
    end
    // Mask must be back to all ones, so the masked-out low nibble fails again.
    run_vector(24'h0000FF, 24'h0000F0, 20'h00078, 0, 24'h0, p, wc, rc, ww, r);
    checks++;
    if (p !== 1'b1 || r !== {1'b1, 20'h00078, 24'h00000F}) begin
      errors++; $display("[TB] FAIL reset_mask_restored got pop=%b rec=%h want 1 %h", p, r, {1'b1, 20'h00078, 24'h00000F});
    end
    @(negedge clock);
    checks++;
    if (fail_count !== 16'd1 || pass_count !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_counts_after got pass=%h fail=%h want 0 1", pass_count, fail_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    cfifo_data = '0; cfifo_rdempty = 1'b1;
    ofifo_data = '0; ofifo_rdempty = 1'b1;
    rfifo_wrfull = 1'b0;
    sc_cmd = 5'd0; sc_data = 24'h0; sc_switching = 1'b0;
    test_reset;
    test_pass;
    test_fail;
    test_bitmask;
    test_mask_with_pop;
    test_mask_during_cmp;
    test_stall;
    test_saturation;
    test_reset_mid_vector;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
